timer_avalon_master: RTL and testbench

- Avalon-MM initiator that programs and services the team's 16-bit-register interval timer slave: the requester-side counterpart of that timer's s1 port.
- Turns simple local commands (start with period, stop, snapshot) into the timer's register write and read sequences.
- Watches the timer irq, clears the status register, and emits one tick pulse per timeout.
- Sits between application logic and the timer instance in the SoC.

---
 rtl/timer_regs_pkg.sv | 42 ++++
 rtl/timer_avalon_master.sv | 156 +++++++++++++++
 tb/tb_timer_avalon_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_regs_pkg.sv
// Register map, control-bit layout and FSM state encoding shared by the interval-timer requester.
// No logic of its own; the constants and helper are pure.
package timer_regs_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    WR_CTRL,
    WR_STOP,
    CLR_ST,
    SNAP_WR,
    SNAP_RD_L,
    SNAP_CAP_L,
    SNAP_RD_H,
    SNAP_CAP_H
  } tmr_state_t;

  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = stop;
    w[CTRL_START] = start;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/timer_avalon_master.sv
// Avalon-MM requester that programs/services the interval timer; snapshot path under TIMER_MASTER_SNAPSHOT_EN.
// Latency: start 3 cycles, stop 1, timeout service 1, snapshot 5 to snap_valid; bus outputs registered.
// Backpressure: none on the bus; requests arriving while busy or losing IDLE arbitration are dropped.
module timer_avalon_master #(
  parameter int   TICK_CNT_W = 16,
  parameter logic CTRL_ITO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  input  logic                  cmd_stop,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic [2:0]            avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write_n,
  output logic [15:0]           avm_writedata,
  input  logic [15:0]           avm_readdata,
  input  logic                  timer_irq
);
  import timer_regs_pkg::*;

  localparam logic [TICK_CNT_W-1:0] TICK_ONE = {{(TICK_CNT_W-1){1'b0}}, 1'b1};

  tmr_state_t  state_q, state_d;
  logic        cs_d, wn_d;
  logic [2:0]  addr_d;
  logic [15:0] wd_d;
  logic [15:0] period_hi_q;
  logic        cont_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      tick           <= 1'b0;
      tick_count     <= '0;
      period_hi_q    <= '0;
      cont_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      avm_chipselect <= cs_d;
      avm_write_n    <= wn_d;
      avm_address    <= addr_d;
      avm_writedata  <= wd_d;
      tick           <= (state_d == CLR_ST);
      if (state_d == CLR_ST)
        tick_count <= tick_count + TICK_ONE;
      if (state_q == IDLE && state_d == WR_PL) begin
        period_hi_q <= cmd_period[31:16];
        cont_q      <= cmd_continuous;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = ADDR_STATUS;
    wd_d    = '0;

    case (state_q)
      IDLE: begin
        if (timer_irq)      state_d = CLR_ST;
        else if (cmd_stop)  state_d = WR_STOP;
        else if (cmd_start) state_d = WR_PL;
`ifdef TIMER_MASTER_SNAPSHOT_EN
        else if (snap_req)  state_d = SNAP_WR;
`endif
      end
      WR_PL:      state_d = WR_PH;
      WR_PH:      state_d = WR_CTRL;
      WR_CTRL:    state_d = IDLE;
      WR_STOP:    state_d = IDLE;
      CLR_ST:     state_d = IDLE;
`ifdef TIMER_MASTER_SNAPSHOT_EN
      SNAP_WR:    state_d = SNAP_RD_L;
      SNAP_RD_L:  state_d = SNAP_CAP_L;
      SNAP_CAP_L: state_d = SNAP_RD_H;
      SNAP_RD_H:  state_d = SNAP_CAP_H;
      SNAP_CAP_H: state_d = IDLE;
`endif
      default:    state_d = IDLE;
    endcase

    // Bus values are chosen for the state being entered so they line up with it.
    case (state_d)
      WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_L; wd_d = cmd_period[15:0];
      end
      WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIOD_H; wd_d = period_hi_q;
      end
      WR_CTRL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;
        wd_d = ctrl_word(1'b0, 1'b1, cont_q, CTRL_ITO);
      end
      WR_STOP: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL;
        wd_d = ctrl_word(1'b1, 1'b0, 1'b0, CTRL_ITO);
      end
      CLR_ST: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;
      end
`ifdef TIMER_MASTER_SNAPSHOT_EN
      SNAP_WR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SNAP_L;
      end
      SNAP_RD_L: begin
        cs_d = 1'b1; addr_d = ADDR_SNAP_L;
      end
      SNAP_RD_H: begin
        cs_d = 1'b1; addr_d = ADDR_SNAP_H;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef TIMER_MASTER_SNAPSHOT_EN
  logic [15:0] snap_lo_q;
  logic [31:0] snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_lo_q <= '0;
      snap_q    <= '0;
    end else begin
      if (state_q == SNAP_CAP_L) snap_lo_q <= avm_readdata;
      if (state_q == SNAP_CAP_H) snap_q    <= {avm_readdata, snap_lo_q};
    end
  end

  // High half arrives during SNAP_CAP_H; present the merged word in that same cycle.
  assign snap_valid = (state_q == SNAP_CAP_H);
  assign snap_value = snap_valid ? {avm_readdata, snap_lo_q} : snap_q;
`else
  logic unused_snap_in;
  assign unused_snap_in = ^{snap_req, avm_readdata};
  assign snap_valid     = 1'b0;
  assign snap_value     = '0;
`endif

endmodule

// File: tb/tb_timer_avalon_master.sv
// Bench for timer_avalon_master: vector table, hand-written corner sequences and random commands
// against a transaction-level model of the expected bus traffic.
module tb_timer_avalon_master;

  localparam int TW = 8;
`ifdef TIMER_MASTER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start, cmd_continuous, cmd_stop, snap_req;
  logic [31:0]   cmd_period;
  logic          busy, snap_valid, tick;
  logic [31:0]   snap_value;
  logic [TW-1:0] tick_count;
  logic [2:0]    avm_address;
  logic          avm_chipselect, avm_write_n;
  logic [15:0]   avm_writedata, avm_readdata;
  logic          timer_irq;

  timer_avalon_master #(.TICK_CNT_W(TW), .CTRL_ITO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_stop(cmd_stop), .snap_req(snap_req),
    .busy(busy), .snap_valid(snap_valid), .snap_value(snap_value),
    .tick(tick), .tick_count(tick_count),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic        busy;
    logic        tick;
    logic        sv;
  } obs_t;

  typedef struct {
    logic        st, sp, sn, iq;
    logic [31:0] per;
    logic        ct;
    int          exp_busy;
    int          exp_beats;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  obs_t        exp_q[$];
  logic [15:0] mem [8];
  int          model_ticks = 0;
  logic [31:0] exp_snap = '0;
  int          nb, nbt;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t mk(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [15:0] d, input logic b, input logic t, input logic v);
    obs_t o;
    o.cs = cs; o.wn = wn; o.addr = a; o.wd = d; o.busy = b; o.tick = t; o.sv = v;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    return mk(avm_chipselect, avm_write_n, avm_address, avm_writedata, busy, tick, snap_valid);
  endfunction

  // Transaction-level expectation: which request wins and the bus beats it produces, cycle by cycle.
  task automatic build_expect(input logic st, input logic sp, input logic sn, input logic iq,
                              input logic [31:0] per, input logic ct);
    exp_q.delete();
    if (iq) begin
      model_ticks++;
      exp_q.push_back(mk(1, 0, 3'd0, 16'h0000, 1, 1, 0));
    end else if (sp) begin
      exp_q.push_back(mk(1, 0, 3'd1, 16'h0009, 1, 0, 0));
    end else if (st) begin
      exp_q.push_back(mk(1, 0, 3'd2, per[15:0], 1, 0, 0));
      exp_q.push_back(mk(1, 0, 3'd3, per[31:16], 1, 0, 0));
      exp_q.push_back(mk(1, 0, 3'd1, {12'h000, 1'b0, 1'b1, ct, 1'b1}, 1, 0, 0));
    end else if (sn && SNAP_EN) begin
      exp_q.push_back(mk(1, 0, 3'd4, 16'h0000, 1, 0, 0));
      exp_q.push_back(mk(1, 1, 3'd4, 16'h0000, 1, 0, 0));
      exp_q.push_back(mk(0, 1, 3'd0, 16'h0000, 1, 0, 0));
      exp_q.push_back(mk(1, 1, 3'd5, 16'h0000, 1, 0, 0));
      exp_q.push_back(mk(0, 1, 3'd0, 16'h0000, 1, 0, 1));
      exp_snap = {mem[5], mem[4]};
    end
    exp_q.push_back(mk(0, 1, 3'd0, 16'h0000, 0, 0, 0));
  endtask

  // Entered and left at a negedge while the DUT sits in IDLE.
  task automatic run_scn(input logic st, input logic sp, input logic sn, input logic iq,
                         input logic [31:0] per, input logic ct, input int irq_mid_at,
                         input logic noise, output int n_busy, output int n_beats);
    build_expect(st, sp, sn, iq, per, ct);
    cmd_start = st; cmd_stop = sp; snap_req = sn; cmd_period = per; cmd_continuous = ct;
    if (iq) timer_irq = 1'b1;
    n_busy = 0; n_beats = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      if (i > 0 && exp_q[i-1].cs && exp_q[i-1].wn) avm_readdata = mem[exp_q[i-1].addr];
      else avm_readdata = 16'hDEAD;
      @(negedge clk);
      cmd_start = 1'b0; cmd_stop = 1'b0; snap_req = 1'b0;
      chk($sformatf("cycle%0d", i), cur_obs(), exp_q[i]);
      if (busy) n_busy++;
      if (avm_chipselect) n_beats++;
      if (exp_q[i].sv) chk("snap_value", snap_value, exp_snap);
      if (exp_q[i].tick) chk("tick_count", tick_count, model_ticks % (1 << TW));
      if (i == exp_q.size() - 1) chk("snap_hold", snap_value, exp_snap);
      if (avm_chipselect && !avm_write_n && avm_address == 3'd0) timer_irq = 1'b0;
      if (i == irq_mid_at) timer_irq = 1'b1;
      if (noise && exp_q[i].busy) begin
        cmd_start = 1'($urandom); cmd_stop = 1'($urandom); snap_req = 1'($urandom);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_start = 0; cmd_stop = 0; snap_req = 0; cmd_continuous = 0;
    cmd_period = '0; timer_irq = 0; avm_readdata = 16'hDEAD;
    for (int k = 0; k < 8; k++) mem[k] = 16'hBAD0 + 16'(k);
    mem[4] = 16'h1234; mem[5] = 16'h0005;

    repeat (2) @(negedge clk);
    chk("reset_bus", cur_obs(), mk(0, 1, 3'd0, 16'h0, 0, 0, 0));
    chk("reset_tick_count", tick_count, 0);
    chk("reset_snap_value", snap_value, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", cur_obs(), mk(0, 1, 3'd0, 16'h0, 0, 0, 0));

    tbl[0] = '{1, 0, 0, 0, 32'h0001_86A0, 1, 3, 3};
    tbl[1] = '{0, 0, 0, 1, 32'h0, 0, 1, 1};
    tbl[2] = '{1, 1, 0, 1, 32'h5555_AAAA, 1, 1, 1};
    tbl[3] = '{0, 1, 0, 0, 32'h0, 0, 1, 1};
    tbl[4] = '{1, 0, 0, 0, 32'h1234_5678, 0, 3, 3};
    tbl[5] = '{0, 0, 1, 0, 32'h0, 0, SNAP_EN ? 5 : 0, SNAP_EN ? 3 : 0};
    tbl[6] = '{1, 0, 1, 0, 32'hFFFF_0000, 1, 3, 3};
    tbl[7] = '{0, 0, 0, 0, 32'h0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      run_scn(tbl[i].st, tbl[i].sp, tbl[i].sn, tbl[i].iq | timer_irq, tbl[i].per, tbl[i].ct,
              -1, 1'b0, nb, nbt);
      chk($sformatf("tbl%0d_busy_cycles", i), nb, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_bus_beats", i), nbt, tbl[i].exp_beats);
    end
    chk("tbl_snap_final", snap_value, SNAP_EN ? 32'h0005_1234 : 32'h0);

    // Timeout re-raised ten cycles after a service.
    run_scn(0, 0, 0, 1, 0, 0, -1, 1'b0, nb, nbt);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("irq_gap_idle", cur_obs(), mk(0, 1, 3'd0, 16'h0, 0, 0, 0));
    end
    run_scn(0, 0, 0, 1, 0, 0, -1, 1'b0, nb, nbt);
    chk("irq_reraise_count", tick_count, 4);

    // irq rising mid-start is serviced right after the sequence.
    run_scn(1, 0, 0, 0, 32'h0BAD_F00D, 0, 1, 1'b0, nb, nbt);
    chk("irq_mid_pending", timer_irq, 1);
    run_scn(0, 0, 0, timer_irq, 0, 0, -1, 1'b0, nb, nbt);
    chk("irq_mid_serviced", nbt, 1);

    // Reset while in WR_PH: control write must never appear.
    cmd_start = 1; cmd_period = 32'hCAFE_F00D; cmd_continuous = 1;
    @(negedge clk);
    cmd_start = 0;
    chk("rst_seq_wr_pl", cur_obs(), mk(1, 0, 3'd2, 16'hF00D, 1, 0, 0));
    @(negedge clk);
    chk("rst_seq_wr_ph", cur_obs(), mk(1, 0, 3'd3, 16'hCAFE, 1, 0, 0));
    reset = 1;
    @(negedge clk);
    chk("rst_seq_idle", cur_obs(), mk(0, 1, 3'd0, 16'h0, 0, 0, 0));
    chk("rst_seq_tick_count", tick_count, 0);
    reset = 0; model_ticks = 0; exp_snap = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_seq_no_ctrl", cur_obs(), mk(0, 1, 3'd0, 16'h0, 0, 0, 0));
    end

    // Counter wrap.
    while ((model_ticks % (1 << TW)) != (1 << TW) - 1)
      run_scn(0, 0, 0, 1, 0, 0, -1, 1'b0, nb, nbt);
    chk("wrap_before", tick_count, 8'hFF);
    run_scn(0, 0, 0, 1, 0, 0, -1, 1'b0, nb, nbt);
    chk("wrap_after", tick_count, 8'h00);

    // Random command mix, including requests thrown at the DUT while busy.
    for (int r = 0; r < 300; r++) begin
      logic st, sp, sn, iq, ct, nz;
      int   mid;
      st = 1'($urandom); sp = ($urandom_range(0, 3) == 0); sn = 1'($urandom);
      iq = ($urandom_range(0, 3) == 0) | timer_irq; ct = 1'($urandom); nz = 1'($urandom);
      mid = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      mem[4] = 16'($urandom); mem[5] = 16'($urandom);
      run_scn(st, sp, sn, iq, $urandom, ct, mid, nz, nb, nbt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
